// File: rtl/walk_request_bank.sv
// Multi-channel walk request bank: it synchronises and debounces the buttons, latches sticky requests, and offers them through a round-robin valid/ack handshake.
// Optional served-request counter is enabled by defining WALK_REQ_COUNT_EN; otherwise req_count is tied to 0.
module walk_request_bank #(
  parameter  int N_CH            = 4,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 16,
  parameter  int CNT_W           = 8,
  localparam int CH_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  wr_btn,
  input  logic [N_CH-1:0]  wr_reset,
  output logic [N_CH-1:0]  wr,
  output logic             req_valid,
  output logic [CH_W-1:0]  req_ch,
  input  logic             req_ack,
  output logic [CNT_W-1:0] req_count
);

  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] synced;
  logic [DB_W-1:0] db_cnt_q [N_CH];
  logic [N_CH-1:0] stable_q;
  logic [N_CH-1:0] stable_d_q;
  logic [N_CH-1:0] press;

  logic [N_CH-1:0] wr_q;
  logic [N_CH-1:0] wr_d;
  logic [N_CH-1:0] grant_mask;
  logic            grant;

  state_t          state_q, state_d;
  logic            req_valid_q, req_valid_d;
  logic [CH_W-1:0] req_ch_q, req_ch_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            pick_found;
  logic [CH_W-1:0] pick_ch;
  logic [CH_W:0]   cand;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: synchroniser and debounce arrays are plain flops, so they are reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= wr_btn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // The stable level flips on the cycle the count of differing samples reaches DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) db_cnt_q[i] <= '0;
      stable_q   <= '0;
      stable_d_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (synced[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          stable_q[i] <= synced[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
      stable_d_q <= stable_q;
    end
  end

  assign press = stable_q & ~stable_d_q;

  assign grant = (state_q == OFFER) & req_valid_q & req_ack;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask[req_ch_q] = 1'b1;
  end

  // A press in the same cycle as a clear wins, so a new request is never dropped.
  assign wr_d = (wr_q & ~(wr_reset | grant_mask)) | press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_q <= '0;
    else        wr_q <= wr_d;
  end

  // Round-robin search: the lowest offset from ptr with a pending bit wins.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (cand >= N_CH_EXT) cand = cand - N_CH_EXT;
      if (wr_q[cand[CH_W-1:0]]) begin
        pick_found = 1'b1;
        pick_ch    = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = 1'b0;
    req_ch_d    = req_ch_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = OFFER;
          req_valid_d = 1'b1;
          req_ch_d    = pick_ch;
        end
      end
      OFFER: begin
        if (grant) begin
          state_d = IDLE;
          ptr_d   = (req_ch_q == LAST_CH) ? '0 : req_ch_q + 1'b1;
        end else if (!wr_d[req_ch_q]) begin
          state_d = IDLE;
        end else begin
          req_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_ch_q    <= req_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign wr        = wr_q;
  assign req_valid = req_valid_q;
  assign req_ch    = req_ch_q;

`ifdef WALK_REQ_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Saturates at all-ones; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       count_q <= '0;
    else if (grant && count_q != '1)  count_q <= count_q + 1'b1;
  end

  assign req_count = count_q;
`else
  assign req_count = '0;
`endif

endmodule
